// File: rtl/signal_table_sequencer.sv
// signal_table_sequencer: plays SignalTable samples to the PWM core and shares the table port with host loads.
// Optional triangle (up/down) playback is built when SEQ_MIRROR_EN is defined; sawtooth otherwise.
module signal_table_sequencer #(
  parameter int unsigned data_width = 8,
  parameter int unsigned addr_width = 7,
  parameter int unsigned data_range = 100,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic [DIV_WIDTH-1:0]  StepDiv,
  input  logic                  LoadValid,
  input  logic [addr_width-1:0] LoadAddr,
  input  logic [data_width-1:0] LoadData,
  output logic                  LoadReady,
  output logic                  WR,
  output logic [addr_width-1:0] address,
  output logic [data_width-1:0] dataIn,
  input  logic [data_width-1:0] dataOut,
  output logic [data_width-1:0] Sample,
  output logic                  SampleValid,
  output logic                  Busy,
  output logic                  Wrap
);
  localparam logic [addr_width-1:0] LAST_IDX = addr_width'(data_range - 1);
  localparam logic [DIV_WIDTH-1:0]  ONE      = DIV_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;

  state_t                state, state_nxt;
  logic [addr_width-1:0] index, index_adv;
  logic [DIV_WIDTH-1:0]  holdcnt;
  logic                  start_go, abort, load_acc, wrap_hit;

  assign start_go = (state == IDLE) && Start && !Stop;
  assign abort    = (state != IDLE) && Stop;

`ifdef SEQ_MIRROR_EN
  logic dir_down;

  // Direction turns down after emitting the last entry and back up after emitting 0.
  always_ff @(posedge Clk) begin
    if (Rst || start_go || abort) begin
      dir_down <= 1'b0;
    end else if (state == WAIT) begin
      if (index == LAST_IDX) begin
        dir_down <= 1'b1;
      end else if (index == '0) begin
        dir_down <= 1'b0;
      end
    end
  end

  assign index_adv = dir_down ? index - addr_width'(1) : index + addr_width'(1);
  assign wrap_hit  = dir_down && (index == '0);
`else
  assign index_adv = (index == LAST_IDX) ? '0 : index + addr_width'(1);
  assign wrap_hit  = (index == LAST_IDX);
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_go) state_nxt = READ;
      READ: state_nxt = Stop ? IDLE : WAIT;
      WAIT: state_nxt = Stop ? IDLE : HOLD;
      HOLD: begin
        if (Stop) begin
          state_nxt = IDLE;
        end else if (holdcnt <= ONE) begin
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Table port: playback owns it in READ/WAIT, host loads get it in IDLE/HOLD.
  always_comb begin
    Busy      = (state != IDLE);
    LoadReady = !Rst && ((state == IDLE) || (state == HOLD));
    load_acc  = LoadValid && LoadReady;
    WR        = 1'b0;
    address   = index;
    dataIn    = '0;
    if (load_acc) begin
      address = LoadAddr;
      dataIn  = LoadData;
      WR      = (32'(LoadAddr) < data_range);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      index       <= '0;
      holdcnt     <= '0;
      Sample      <= '0;
      SampleValid <= 1'b0;
      Wrap        <= 1'b0;
    end else begin
      SampleValid <= 1'b0;
      Wrap        <= 1'b0;
      if (abort) begin
        index <= '0;
      end else begin
        case (state)
          IDLE: if (start_go) index <= '0;
          WAIT: begin
            Sample      <= dataOut;
            SampleValid <= 1'b1;
            Wrap        <= wrap_hit;
            holdcnt     <= (StepDiv == '0) ? ONE : StepDiv;
          end
          HOLD: begin
            holdcnt <= holdcnt - ONE;
            if (holdcnt <= ONE) index <= index_adv;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_signal_table_sequencer.sv
// Randomized bench for signal_table_sequencer against a cycle-scheduled playback model and a shadow table.
module tb_signal_table_sequencer;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 7;
  localparam int unsigned N   = 10;
  localparam int unsigned DVW = 16;

  logic          Clk = 1'b0;
  logic          Rst, Start, Stop, LoadValid, LoadReady, WR, SampleValid, Busy, Wrap;
  logic [DVW-1:0] StepDiv;
  logic [AW-1:0] LoadAddr, address;
  logic [DW-1:0] LoadData, dataIn, dataOut, Sample;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] sm  [2**AW];

  int   checks = 0;
  int   errors = 0;
  int   cyc, emit_at, k;
  bit   running, exp_sv, exp_wrap;
  logic [DW-1:0] exp_sample;

  always #5 Clk = ~Clk;

  // Synchronous-read table model standing in for SignalTable.
  always @(posedge Clk) begin
    if (WR) mem[address] <= dataIn;
    dataOut <= mem[address];
  end

  signal_table_sequencer #(
    .data_width(DW), .addr_width(AW), .data_range(N), .DIV_WIDTH(DVW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .StepDiv(StepDiv),
    .LoadValid(LoadValid), .LoadAddr(LoadAddr), .LoadData(LoadData), .LoadReady(LoadReady),
    .WR(WR), .address(address), .dataIn(dataIn), .dataOut(dataOut),
    .Sample(Sample), .SampleValid(SampleValid), .Busy(Busy), .Wrap(Wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Table index of the kk-th sample since Start.
  function automatic int idx_of(input int kk);
`ifdef SEQ_MIRROR_EN
    int p;
    p = kk % (2 * N - 2);
    return (p < N) ? p : (2 * N - 2 - p);
`else
    return kk % N;
`endif
  endfunction

  function automatic bit wrap_of(input int kk);
`ifdef SEQ_MIRROR_EN
    return (kk > 0) && (kk % (2 * N - 2) == 0);
`else
    return (kk % N) == N - 1;
`endif
  endfunction

  // Check this cycle at negedge, then advance the model across the next rising edge.
  task automatic step();
    bit rdy, acc, nsv, nwrap;
    int div;
    @(negedge Clk);
    check("busy", 32'(Busy), 32'(running));
    check("sample", 32'(Sample), 32'(exp_sample));
    check("sample_valid", 32'(SampleValid), 32'(exp_sv));
    check("wrap", 32'(Wrap), 32'(exp_wrap));
    rdy = !running || ((cyc != emit_at - 2) && (cyc != emit_at - 1));
    acc = 1'b0;
    if (Rst) begin
      check("wr_in_reset", 32'(WR), 32'd0);
    end else begin
      check("load_ready", 32'(LoadReady), 32'(rdy));
      acc = LoadValid && rdy;
      if (acc) begin
        check("wr_load", 32'(WR), 32'(LoadAddr < N));
        check("addr_load", 32'(address), 32'(LoadAddr));
        if (LoadAddr < N) check("data_in_load", 32'(dataIn), 32'(LoadData));
      end else begin
        check("wr_idle", 32'(WR), 32'd0);
        check("data_in_idle", 32'(dataIn), 32'd0);
        if (running && cyc == emit_at - 2) check("read_addr", 32'(address), 32'(idx_of(k)));
      end
    end
    nsv   = 1'b0;
    nwrap = 1'b0;
    if (Rst) begin
      running    = 1'b0;
      exp_sample = '0;
    end else begin
      if (acc && LoadAddr < N) sm[LoadAddr] = LoadData;
      if (!running) begin
        if (Start && !Stop) begin
          running = 1'b1;
          emit_at = cyc + 3;
          k       = 0;
        end
      end else if (Stop) begin
        running = 1'b0;
      end else if (cyc == emit_at - 1) begin
        exp_sample = sm[idx_of(k)];
        nsv        = 1'b1;
        nwrap      = wrap_of(k);
        k++;
        div        = (StepDiv == 0) ? 1 : int'(StepDiv);
        emit_at    = cyc + 1 + div + 2;
      end
    end
    exp_sv   = nsv;
    exp_wrap = nwrap;
    cyc++;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Stop = 1'b0; StepDiv = '0;
    LoadValid = 1'b0; LoadAddr = '0; LoadData = '0;
    cyc = 0; running = 1'b0; k = 0; emit_at = 0;
    exp_sample = '0; exp_sv = 1'b0; exp_wrap = 1'b0;
    @(posedge Clk);
    #1;
    step(); step();
    Rst = 1'b0;

    // Fill the table with k*3, then one out-of-range load.
    for (int a = 0; a < int'(N); a++) begin
      LoadValid = 1'b1; LoadAddr = AW'(a); LoadData = DW'(a * 3);
      step();
    end
    LoadAddr = 7'd120; LoadData = 8'hEE;
    step();
    LoadValid = 1'b0;

    // Period 4 playback across a full wrap.
    StepDiv = 16'd2; Start = 1'b1; step(); Start = 1'b0;
    repeat (48) step();
    Stop = 1'b1; step(); Stop = 1'b0; step();

    // StepDiv of 0 behaves as 1.
    StepDiv = 16'd0; Start = 1'b1; step(); Start = 1'b0;
    repeat (36) step();
    Stop = 1'b1; step(); Stop = 1'b0;

    // Host loads held continuously during playback.
    StepDiv = 16'd3; Start = 1'b1; step(); Start = 1'b0;
    LoadValid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      LoadAddr = (i % 8 == 7) ? 7'd120 : AW'($urandom_range(0, N - 1));
      LoadData = DW'($urandom);
      step();
    end
    LoadValid = 1'b0;
    Stop = 1'b1; step(); Stop = 1'b0;

    // Stop during WAIT, then Start+Stop together in IDLE.
    Start = 1'b1; step(); Start = 1'b0; step();
    Stop = 1'b1; step(); Stop = 1'b0; step(); step();
    Start = 1'b1; Stop = 1'b1; step(); Start = 1'b0; Stop = 1'b0; step(); step();

    // Two-cycle reset in the middle of playback.
    StepDiv = 16'd1; Start = 1'b1; step(); Start = 1'b0;
    repeat (9) step();
    Rst = 1'b1; step(); step(); Rst = 1'b0;
    step(); step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      Rst       = ($urandom_range(0, 299) == 0);
      Start     = ($urandom_range(0, 7) == 0);
      Stop      = ($urandom_range(0, 39) == 0);
      StepDiv   = DVW'($urandom_range(0, 4));
      LoadValid = $urandom_range(0, 1) == 1;
      LoadAddr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(N, 127)) : AW'($urandom_range(0, N - 1));
      LoadData  = DW'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
